// File: rtl/axi4lite_cmd_master.sv
// rtl/axi4lite_cmd_master.sv - AXI4-Lite initiator driven by a valid/ready command stream
// One transaction in flight; results are returned on a valid/ready response stream.
module axi4lite_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              io_cmd_valid,
    output logic              io_cmd_ready,
    input  logic              io_cmd_write,
    input  logic [ADDR_W-1:0] io_cmd_addr,
    input  logic [31:0]       io_cmd_wdata,
    input  logic [3:0]        io_cmd_wstrb,

    output logic              io_rsp_valid,
    input  logic              io_rsp_ready,
    output logic              io_rsp_write,
    output logic [31:0]       io_rsp_rdata,
    output logic [1:0]        io_rsp_resp,

    output logic [ADDR_W-1:0] io_axi_write_awaddr,
    output logic              io_axi_write_awvalid,
    input  logic              io_axi_write_awready,
    output logic [31:0]       io_axi_write_wdata,
    output logic [3:0]        io_axi_write_wstrb,
    output logic              io_axi_write_wvalid,
    input  logic              io_axi_write_wready,
    input  logic [1:0]        io_axi_write_bresp,
    input  logic              io_axi_write_bvalid,
    output logic              io_axi_write_bready,

    output logic [ADDR_W-1:0] io_axi_read_araddr,
    output logic              io_axi_read_arvalid,
    input  logic              io_axi_read_arready,
    input  logic [31:0]       io_axi_read_rdata,
    input  logic [1:0]        io_axi_read_rresp,
    input  logic              io_axi_read_rvalid,
    output logic              io_axi_read_rready,

    output logic              io_busy,
    output logic              io_timeout
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RA, S_RD, S_RSP} state_t;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              write_q, write_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        resp_q, resp_d;
    logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;

    logic aw_fire, w_fire, b_fire, ar_fire, r_fire, any_hs, counting;

    always_comb begin
        aw_fire  = awvalid_q & io_axi_write_awready;
        w_fire   = wvalid_q & io_axi_write_wready;
        b_fire   = bready_q & io_axi_write_bvalid;
        ar_fire  = arvalid_q & io_axi_read_arready;
        r_fire   = rready_q & io_axi_read_rvalid;
        any_hs   = aw_fire | w_fire | b_fire | ar_fire | r_fire;
        counting = (state_q == S_WR) || (state_q == S_WB) ||
                   (state_q == S_RA) || (state_q == S_RD);

        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        write_d     = write_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        wd_cnt_d    = wd_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (io_cmd_valid && cmd_ready_q) begin
                    addr_d      = io_cmd_addr;
                    wdata_d     = io_cmd_wdata;
                    wstrb_d     = io_cmd_wstrb;
                    write_d     = io_cmd_write;
                    cmd_ready_d = 1'b0;
                    wd_cnt_d    = '0;
                    if (io_cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_RA;
                    end
                end
            end
            S_WR: begin
                // AW and W complete independently; B is only awaited once both are gone.
                if (aw_fire) awvalid_d = 1'b0;
                if (w_fire)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_WB;
                end
            end
            S_WB: begin
                if (b_fire) begin
                    bready_d    = 1'b0;
                    resp_d      = io_axi_write_bresp;
                    rdata_d     = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RA: begin
                if (ar_fire) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD;
                end
            end
            S_RD: begin
                if (r_fire) begin
                    rready_d    = 1'b0;
                    rdata_d     = io_axi_read_rdata;
                    resp_d      = io_axi_read_rresp;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                if (io_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase

        // Watchdog only flags a stall; the AXI transaction keeps waiting.
        if (counting) begin
            if (any_hs) begin
                wd_cnt_d = '0;
            end else if (wd_cnt_q != CNT_MAX) begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end
        timeout_d = timeout_q | ((TIMEOUT != 0) && counting && (wd_cnt_d == CNT_MAX));
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= '0;
            wd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            write_q     <= write_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

    assign io_cmd_ready         = cmd_ready_q;
    assign io_rsp_valid         = rsp_valid_q;
    assign io_rsp_write         = write_q;
    assign io_rsp_rdata         = rdata_q;
    assign io_rsp_resp          = resp_q;
    assign io_axi_write_awaddr  = addr_q;
    assign io_axi_write_awvalid = awvalid_q;
    assign io_axi_write_wdata   = wdata_q;
    assign io_axi_write_wstrb   = wstrb_q;
    assign io_axi_write_wvalid  = wvalid_q;
    assign io_axi_write_bready  = bready_q;
    assign io_axi_read_araddr   = addr_q;
    assign io_axi_read_arvalid  = arvalid_q;
    assign io_axi_read_rready   = rready_q;
    assign io_busy              = busy_q;
    assign io_timeout           = timeout_q;

endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// tb/tb_axi4lite_cmd_master.sv - directed self-checking bench for axi4lite_cmd_master
// A small AXI4-Lite slave model with delay knobs answers the DUT; checks sample on the falling edge.
module tb_axi4lite_cmd_master;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        busy, timeout;

    int          aw_wait = 0, aw_age = 0;
    logic        ar_block = 1'b0, b_hold = 1'b0;
    logic [31:0] rdata_val = '0;
    logic [1:0]  rresp_val = '0, bresp_val = '0;
    logic        aw_done = 1'b0, w_done = 1'b0;
    int          aw_hs = 0, w_hs = 0, b_hs = 0;
    int          tests = 0, fails = 0;

    always #5 clock = ~clock;

    axi4lite_cmd_master #(.ADDR_W(32), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .io_cmd_valid(cmd_valid), .io_cmd_ready(cmd_ready), .io_cmd_write(cmd_write),
        .io_cmd_addr(cmd_addr), .io_cmd_wdata(cmd_wdata), .io_cmd_wstrb(cmd_wstrb),
        .io_rsp_valid(rsp_valid), .io_rsp_ready(rsp_ready), .io_rsp_write(rsp_write),
        .io_rsp_rdata(rsp_rdata), .io_rsp_resp(rsp_resp),
        .io_axi_write_awaddr(awaddr), .io_axi_write_awvalid(awvalid), .io_axi_write_awready(awready),
        .io_axi_write_wdata(wdata), .io_axi_write_wstrb(wstrb), .io_axi_write_wvalid(wvalid),
        .io_axi_write_wready(wready), .io_axi_write_bresp(bresp), .io_axi_write_bvalid(bvalid),
        .io_axi_write_bready(bready),
        .io_axi_read_araddr(araddr), .io_axi_read_arvalid(arvalid), .io_axi_read_arready(arready),
        .io_axi_read_rdata(rdata), .io_axi_read_rresp(rresp), .io_axi_read_rvalid(rvalid),
        .io_axi_read_rready(rready),
        .io_busy(busy), .io_timeout(timeout)
    );

    assign awready = (aw_age >= aw_wait);
    assign wready  = 1'b1;
    assign arready = ~ar_block;
    assign bresp   = bresp_val;

    // Slave model: B follows once both AW and W have been taken; R follows AR by one cycle.
    always @(posedge clock) begin
        if (reset) begin
            aw_age  <= 0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bvalid  <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= '0;
        end else begin
            if (awvalid && awready) begin
                aw_hs  <= aw_hs + 1;
                aw_age <= 0;
            end else if (awvalid) begin
                aw_age <= aw_age + 1;
            end
            if (wvalid && wready) w_hs <= w_hs + 1;
            if (bvalid && bready) begin
                b_hs   <= b_hs + 1;
                bvalid <= 1'b0;
            end else if ((aw_done || (awvalid && awready)) && (w_done || (wvalid && wready))
                         && !bvalid && !b_hold) begin
                bvalid  <= 1'b1;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (awvalid && awready) aw_done <= 1'b1;
                if (wvalid && wready)   w_done  <= 1'b1;
            end
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= rdata_val;
                rresp  <= rresp_val;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the DUT idle; returns just after the accepting edge.
    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        chk("cmd_ready_before_cmd", cmd_ready, 1);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cmd_wdata = '0;
        cmd_addr  = '0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (rsp_valid) break;
        end
    endtask

    int n, aw0, w0, b0, first;

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("reset_state",
            {60'd0, cmd_ready, busy, timeout, rsp_valid},
            {60'd0, 4'b1000});
        chk("reset_axi_valids",
            {58'd0, awvalid, wvalid, bready, arvalid, rready, rsp_write},
            64'd0);

        // 1: write, always-ready slave
        send_cmd(1'b1, 32'h0, 32'h1, 4'hF);
        @(negedge clock);
        chk("t1_aw_w_valid", {awvalid, wvalid, busy}, 3'b111);
        chk("t1_aw_payload", {awaddr, wdata}, {32'h0, 32'h1});
        chk("t1_wstrb", wstrb, 4'hF);
        @(posedge clock);
        @(negedge clock);
        chk("t1_after_aw_w", {awvalid, wvalid, bready}, 3'b001);
        @(posedge clock);
        @(negedge clock);
        chk("t1_rsp_valid_at_T3", rsp_valid, 1);
        chk("t1_rsp_fields", {rsp_write, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'h0});
        @(posedge clock);
        @(negedge clock);
        chk("t1_back_idle", {rsp_valid, cmd_ready, busy}, 3'b010);

        // 2: awready delayed, wready immediate
        aw_wait = 5;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        send_cmd(1'b1, 32'h10, 32'hA5A5_0001, 4'h3);
        @(negedge clock);
        chk("t2_both_valid", {awvalid, wvalid}, 2'b11);
        @(posedge clock);
        @(negedge clock);
        chk("t2_wvalid_dropped", {awvalid, wvalid}, 2'b10);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("t2_aw_stable_%0d", i), {awvalid, awaddr}, {1'b1, 32'h10});
        end
        wait_rsp(n);
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_handshakes", {aw_hs - aw0, w_hs - w0, b_hs - b0}, {32'd1, 32'd1, 32'd1});
        @(posedge clock);
        @(negedge clock);
        aw_wait = 0;

        // 3: read with SLVERR
        rdata_val = 32'hDEAD_BEEF;
        rresp_val = 2'b10;
        send_cmd(1'b0, 32'h1C, 32'h0, 4'h0);
        @(negedge clock);
        chk("t3_ar", {arvalid, awvalid, araddr}, {2'b10, 32'h1C});
        wait_rsp(n);
        chk("t3_latency", n, 2);
        chk("t3_rsp_fields", {rsp_write, rsp_resp, rsp_rdata}, {1'b0, 2'b10, 32'hDEAD_BEEF});
        @(posedge clock);
        @(negedge clock);

        // 4: response back-pressure
        rsp_ready = 1'b0;
        bresp_val = 2'b01;
        send_cmd(1'b1, 32'h4, 32'h55, 4'h1);
        wait_rsp(n);
        chk("t4_latency", n, 2);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("t4_hold_%0d", i),
                {rsp_valid, rsp_write, rsp_resp, rsp_rdata, cmd_ready, awvalid, wvalid, arvalid},
                {1'b1, 1'b1, 2'b01, 32'h0, 4'b0000});
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("t4_release", {rsp_valid, cmd_ready}, 2'b01);
        bresp_val = 2'b00;

        // 5: watchdog with arready stuck low
        ar_block = 1'b1;
        rdata_val = 32'h1234_5678;
        rresp_val = 2'b00;
        chk("t5_timeout_clear", timeout, 0);
        send_cmd(1'b0, 32'h8, 32'h0, 4'h0);
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (timeout && first == 0) first = k;
        end
        chk("t5_timeout_cycle", first, 16);
        chk("t5_arvalid_held", {arvalid, araddr}, {1'b1, 32'h8});
        ar_block = 1'b0;
        wait_rsp(n);
        chk("t5_read_completes", {rsp_valid, rsp_rdata}, {1'b1, 32'h1234_5678});
        chk("t5_timeout_sticky", timeout, 1);
        @(posedge clock);
        @(negedge clock);

        // 6: reset while waiting on B
        b_hold = 1'b1;
        send_cmd(1'b1, 32'h18, 32'hCAFE_F00D, 4'hF);
        @(posedge clock);
        @(negedge clock);
        chk("t6_in_wb", {bready, busy, awvalid, wvalid}, 4'b1100);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("t6_reset_outputs",
            {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy, timeout}, 8'h00);
        reset = 1'b0;
        b_hold = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("t6_cmd_ready_after", {cmd_ready, busy}, 2'b10);

        rdata_val = 32'h0BAD_F00D;
        send_cmd(1'b0, 32'h1C, 32'h0, 4'h0);
        wait_rsp(n);
        chk("t6_recover_read", {n, rsp_rdata}, {32'd2, 32'h0BAD_F00D});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
